// File: rtl/count_disp_pkg.sv
// rtl/count_disp_pkg.sv - shared types, constants and helpers for count_display_driver
package count_disp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        COMMIT
    } disp_state_e;

    localparam int NUM_DIGITS = 3;

    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Active-high segment codes, bit order {g,f,e,d,c,b,a}, index = nibble value
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    // Double-dabble correction: every BCD nibble of 5 or more gets +3 before the shift
    function automatic logic [11:0] dd_adjust(input logic [11:0] v);
        logic [11:0] r;
        r = v;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (v[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = v[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/count_display_driver_if.sv
// rtl/count_display_driver_if.sv - load/convert/commit handshake between counter and display driver
interface count_display_driver_if;
    logic [7:0]  count_in;
    logic        load;
    logic        mode;
    logic        busy;
    logic        bcd_valid;
    logic [11:0] digits;

    modport master (
        output count_in, load, mode,
        input  busy, bcd_valid, digits
    );

    modport slave (
        input  count_in, load, mode,
        output busy, bcd_valid, digits
    );
endinterface

// File: rtl/seg7_encode.sv
// rtl/seg7_encode.sv - combinational nibble to 7-segment code with blanking
module seg7_encode
    import count_disp_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] seg
);

    assign seg = blank ? SEG_BLANK : SEG_TABLE[nibble];

endmodule

// File: rtl/count_display_driver.sv
// rtl/count_display_driver.sv - sequential double-dabble converter and multiplexed 7-segment scanner
// Optional leading-zero blanking enabled by defining DISP_LZ_BLANK_EN.
module count_display_driver
    import count_disp_pkg::*;
#(
    parameter int SCAN_DIV_W = 10
) (
    input  logic                       clk,
    input  logic                       rst_n,
    count_display_driver_if.slave      bus,
    output logic [6:0]                 seg,
    output logic                       dp,
    output logic [2:0]                 dig_en
);

    localparam logic [SCAN_DIV_W-1:0] PRE_ONE = 1;

    disp_state_e state_q, state_nxt;
    logic [7:0]  bin_q, bin_nxt;
    logic [11:0] bcd_q, bcd_nxt;
    logic [2:0]  bit_cnt_q, bit_cnt_nxt;
    logic        conv_mode_q, conv_mode_nxt;
    logic [11:0] digits_q, digits_nxt;
    logic        disp_mode_q, disp_mode_nxt;
    logic        valid_q, valid_nxt;
    logic [11:0] bcd_adj;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q     <= IDLE;
            bin_q       <= 8'h00;
            bcd_q       <= 12'h000;
            bit_cnt_q   <= 3'd0;
            conv_mode_q <= 1'b0;
            digits_q    <= 12'h000;
            disp_mode_q <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_nxt;
            bin_q       <= bin_nxt;
            bcd_q       <= bcd_nxt;
            bit_cnt_q   <= bit_cnt_nxt;
            conv_mode_q <= conv_mode_nxt;
            digits_q    <= digits_nxt;
            disp_mode_q <= disp_mode_nxt;
            valid_q     <= valid_nxt;
        end
    end

    always_comb begin
        state_nxt     = state_q;
        bin_nxt       = bin_q;
        bcd_nxt       = bcd_q;
        bit_cnt_nxt   = bit_cnt_q;
        conv_mode_nxt = conv_mode_q;
        digits_nxt    = digits_q;
        disp_mode_nxt = disp_mode_q;
        valid_nxt     = 1'b0;
        bcd_adj       = dd_adjust(bcd_q);
        case (state_q)
            IDLE: begin
                if (bus.load) begin
                    bin_nxt       = bus.count_in;
                    conv_mode_nxt = bus.mode;
                    bcd_nxt       = 12'h000;
                    bit_cnt_nxt   = 3'd0;
                    state_nxt     = SHIFT;
                end
            end
            SHIFT: begin
                // Hex rotates so the original byte is back in place after eight steps
                if (conv_mode_q) begin
                    bin_nxt = {bin_q[6:0], bin_q[7]};
                end else begin
                    {bcd_nxt, bin_nxt} = {bcd_adj[10:0], bin_q, 1'b0};
                end
                bit_cnt_nxt = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    state_nxt = COMMIT;
                end
            end
            COMMIT: begin
                digits_nxt    = conv_mode_q ? {4'h0, bin_q} : bcd_q;
                disp_mode_nxt = conv_mode_q;
                valid_nxt     = 1'b1;
                state_nxt     = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign bus.busy      = (state_q != IDLE);
    assign bus.bcd_valid = valid_q;
    assign bus.digits    = digits_q;

    logic [SCAN_DIV_W-1:0] prescaler_q;
    logic [1:0]            idx_q, idx_nxt;
    logic                  scan_tick;
    logic [3:0]            scan_nibble;
    logic                  scan_blank;
    logic [6:0]            seg_nxt;
    logic [2:0]            dig_en_nxt;

    assign scan_tick = &prescaler_q;
    assign idx_nxt   = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;

    always_comb begin
        scan_nibble = 4'h0;
        dig_en_nxt  = 3'b000;
        case (idx_nxt)
            2'd0: begin
                scan_nibble = digits_q[3:0];
                dig_en_nxt  = 3'b001;
            end
            2'd1: begin
                scan_nibble = digits_q[7:4];
                dig_en_nxt  = 3'b010;
            end
            default: begin
                scan_nibble = digits_q[11:8];
                dig_en_nxt  = 3'b100;
            end
        endcase
    end

`ifdef DISP_LZ_BLANK_EN
    always_comb begin
        scan_blank = 1'b0;
        if (idx_nxt == 2'd2) begin
            scan_blank = (digits_q[11:8] == 4'h0);
        end else if (idx_nxt == 2'd1) begin
            scan_blank = (digits_q[11:8] == 4'h0) && (digits_q[7:4] == 4'h0);
        end
    end
`else
    assign scan_blank = 1'b0;
`endif

    seg7_encode u_seg7_encode (
        .nibble (scan_nibble),
        .blank  (scan_blank),
        .seg    (seg_nxt)
    );

    // Outputs move together on the tick so no cycle shows a mixed digit/segment pair
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            prescaler_q <= '0;
            idx_q       <= 2'd2;
            seg         <= SEG_BLANK;
            dp          <= 1'b0;
            dig_en      <= 3'b000;
        end else begin
            prescaler_q <= prescaler_q + PRE_ONE;
            if (scan_tick) begin
                idx_q  <= idx_nxt;
                seg    <= seg_nxt;
                dp     <= (idx_nxt == 2'd0) && disp_mode_q;
                dig_en <= dig_en_nxt;
            end
        end
    end

endmodule

// File: doc/count_display_driver.md
# count_display_driver

Display back-end for the 8-bit up/down counter: consumes the counter value, converts it to three BCD digits (or three hex nibbles) with a sequential double-dabble engine, and time-multiplexes the result onto a common 7-segment bus with one-hot digit enables. It sits directly downstream of the counter and drives the dedicated output pins.

## Interface
- SCAN_DIV_W, 10: prescaler width; each digit is held for 2^SCAN_DIV_W clk cycles.
- clk  input  1  clock, all state on rising edge.
- rst_n  input  1  reset: rst_n, asynchronous, active-high; clock clk.
- count_in  input  8  unsigned counter value to display.
- load  input  1  single-cycle strobe; samples count_in and mode when idle.
- mode  input  1  0 = decimal (BCD), 1 = hexadecimal.
- busy  output  1  conversion in progress; load ignored while high.
- bcd_valid  output  1  one-cycle pulse when a new value is committed to the display.
- digits  output  12  committed digits {d2,d1,d0}, 4 bits each.
- seg  output  7  segment drive, active-high, order {g,f,e,d,c,b,a}.
- dp  output  1  decimal point; lit only while digit 0 is selected and committed mode is hex.
- dig_en  output  3  one-hot digit select, bit 0 = least significant digit.

## Operation
- FSM states: IDLE, SHIFT, COMMIT.
- IDLE: busy=0. On load=1, latch count_in into shift register, latch mode, clear 12-bit BCD accumulator and 3-bit bit counter; go SHIFT.
- SHIFT: 8 cycles. Decimal: each cycle add 3 to every BCD nibble ≥ 5, then shift {bcd,bin} left one bit. Hex: plain shift of the binary register, no add-3. After 8th shift go COMMIT.
- COMMIT: 1 cycle. Write digits (decimal: accumulator; hex: {4'h0, bin[7:4], bin[3:0]}), committed mode, pulse bcd_valid; go IDLE.
- load while busy=1: ignored, no queuing. count_in changes while busy: no effect on the conversion in flight.
- Range: 0..255 decimal gives d2 ≤ 2; hex d2 always 0.
- Scan: free-running SCAN_DIV_W-bit prescaler wraps at all-ones; on wrap (scan tick) digit index advances 0→1→2→0 and seg/dig_en/dp are registered from the committed digits for the new index. Scanning is independent of the FSM; a commit takes effect at the next scan tick.
- Segment code: 0–9 and A–F standard; nibble values decode per the hex table; blank = 7'h00.
- Reset mid-conversion: FSM returns to IDLE immediately, conversion discarded, no bcd_valid.

## Timing
- Reset values: busy=0, bcd_valid=0, digits=12'h000, seg=7'h00, dp=0, dig_en=3'b000, prescaler=0, digit index=2 (so first tick selects digit 0), FSM=IDLE, committed mode=0.
- load sampled at edge N → busy high from N; bcd_valid and digits updated at edge N+9; busy low after edge N+9; next load accepted at edge N+9 when it is IDLE again.
- Throughput: one conversion per 9 cycles maximum.
- First scan tick: edge 2^SCAN_DIV_W after reset release; dig_en=001 from then on, exactly one bit set.
- seg/dig_en/dp change only on scan ticks, always together (no ghosting cycle).

## Configuration
- DISP_LZ_BLANK_EN defined: leading-zero blanking — d2 blanked when 0; d1 blanked when d2 and d1 are both 0; d0 never blanked. Blanking applies in both modes. dig_en still scans all three digits.
- Undefined: all three digits always displayed, including zeros.

## Structure
- Package count_disp_pkg: FSM state enum, NUM_DIGITS=3, SEG_BLANK constant, 16-entry segment code table.
- Sub-module seg7_encode: combinational 4-bit nibble + blank flag → 7-bit segment code; instantiated once on the scan path.

## Test plan
- Bench uses SCAN_DIV_W=2. Reset, hold 20 cycles → busy=0, digits=000, dig_en cycles 001→010→100 every 4 cycles, seg shows '0' (7'h3F) on each digit (without DISP_LZ_BLANK_EN).
- load with count_in=8'd255, mode=0 → busy for 9 cycles, bcd_valid pulse at N+9, digits=12'h255; scanned seg 7'h6D,7'h6D,7'h5B for d0,d1,d2.
- load count_in=8'hAB, mode=1 → digits=12'h0AB; on digit 0 seg=7'h7C ('b'), dp=1; digit 1 seg=7'h77 ('A').
- load at N, second load at N+3 with a different value → ignored; only first value committed, single bcd_valid.
- Assert rst_n at N+4 during a conversion → no bcd_valid, digits unchanged from reset, next load converts normally.
- With DISP_LZ_BLANK_EN, load 8'd7 decimal → d2 and d1 seg=7'h00, d0 seg=7'h07; load 8'd0 → only d0 shows 7'h3F.
